// File: rtl/tune_sequencer.sv
// Note sequencer: 8-deep note FIFO feeding a square-wave tone generator with per-note beat timing and a silent gap.
// Optional build macro TUNE_SEQ_LOOP_EN adds the 'loop' input that re-queues each popped note at the FIFO tail.
module tune_sequencer #(
   parameter int PRESCALE   = 93,
   parameter int BEAT_TICKS = 512,
   parameter int GAP_TICKS  = 64
) (
   input  logic        wb_clk_i,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        note_valid,
   input  logic [11:0] note_data,
   output logic        note_ready,
`ifdef TUNE_SEQ_LOOP_EN
   input  logic        loop,
`endif
   output logic        tone_out,
   output logic        note_start,
   output logic        busy,
   output logic [3:0]  fifo_level
);

   localparam int PW = (PRESCALE > 1)   ? $clog2(PRESCALE)   : 1;
   localparam int BW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
   localparam int GW = (GAP_TICKS > 1)  ? $clog2(GAP_TICKS)  : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [BW-1:0] BEAT_LAST  = BW'(BEAT_TICKS - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TICKS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_GAP
   } state_t;

   state_t          r_state;
   logic            r_tone;
   logic            r_noteStart;
   logic            r_busy;
   logic [7:0]      r_hp;
   logic [4:0]      r_beatsLeft;
   logic [PW-1:0]   r_presc;
   logic [7:0]      r_half;
   logic [BW-1:0]   r_beat;
   logic [GW-1:0]   r_gap;

   logic [11:0]     r_mem [8];
   logic [2:0]      r_wrPtr;
   logic [2:0]      r_rdPtr;
   logic [3:0]      r_level;

   logic            w_tick;
   logic            w_noteEnd;
   logic            w_gapEnd;
   logic            w_pop;
   logic            w_push;
   logic            w_loopWr;
   logic            w_wrEn;
   logic [11:0]     w_head;
   logic [11:0]     w_wrData;

   assign w_head    = r_mem[r_rdPtr];
   assign w_tick    = (r_presc == PRESC_LAST);
   assign w_noteEnd = (r_state == S_PLAY) && w_tick && (r_beat == BEAT_LAST) && (r_beatsLeft == 5'd0);
   assign w_gapEnd  = (r_state == S_GAP) && w_tick && (r_gap == GAP_LAST);

   // A pop only ever happens at a note boundary: from IDLE, or straight out of the gap.
   assign w_pop = enable && (r_level != 4'd0) && ((r_state == S_IDLE) || w_gapEnd);

`ifdef TUNE_SEQ_LOOP_EN
   assign w_loopWr = w_pop & loop;
`else
   assign w_loopWr = 1'b0;
`endif

   // The looped write-back owns the tail slot this cycle, so the host is held off.
   assign note_ready = (r_level != 4'd8) && !w_loopWr;
   assign w_push     = note_valid && note_ready;
   assign w_wrEn     = w_push || w_loopWr;
   assign w_wrData   = w_loopWr ? w_head : note_data;

   assign tone_out   = r_tone;
   assign note_start = r_noteStart;
   assign busy       = r_busy;
   assign fifo_level = r_level;

   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         r_wrPtr <= 3'd0;
         r_rdPtr <= 3'd0;
         r_level <= 4'd0;
      end else begin
         if (w_wrEn) begin
            r_mem[r_wrPtr] <= w_wrData;
            r_wrPtr        <= r_wrPtr + 3'd1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 3'd1;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 4'd1;
         end else if (w_pop && !w_push && !w_loopWr) begin
            r_level <= r_level - 4'd1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_tone      <= 1'b0;
         r_noteStart <= 1'b0;
         r_busy      <= 1'b0;
         r_hp        <= 8'd0;
         r_beatsLeft <= 5'd0;
         r_presc     <= '0;
         r_half      <= 8'd0;
         r_beat      <= '0;
         r_gap       <= '0;
      end else begin
         r_noteStart <= 1'b0;
         if (w_pop) begin
            r_state     <= S_PLAY;
            r_noteStart <= 1'b1;
            r_busy      <= 1'b1;
            r_tone      <= 1'b0;
            r_hp        <= w_head[11:4];
            r_beatsLeft <= {1'b0, w_head[3:0]};
            r_presc     <= '0;
            r_half      <= 8'd0;
            r_beat      <= '0;
            r_gap       <= '0;
         end else if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_tone  <= 1'b0;
            r_presc <= '0;
            r_half  <= 8'd0;
            r_beat  <= '0;
            r_gap   <= '0;
         end else begin
            case (r_state)
               S_PLAY: begin
                  r_presc <= w_tick ? '0 : r_presc + 1'b1;
                  if (w_noteEnd) begin
                     r_state <= S_GAP;
                     r_tone  <= 1'b0;
                     r_half  <= 8'd0;
                     r_beat  <= '0;
                     r_gap   <= '0;
                  end else if (w_tick) begin
                     // A zero half-period is a rest: the tone never leaves 0.
                     if (r_hp != 8'd0) begin
                        if (r_half == r_hp - 8'd1) begin
                           r_half <= 8'd0;
                           r_tone <= ~r_tone;
                        end else begin
                           r_half <= r_half + 8'd1;
                        end
                     end
                     if (r_beat == BEAT_LAST) begin
                        r_beat      <= '0;
                        r_beatsLeft <= r_beatsLeft - 5'd1;
                     end else begin
                        r_beat <= r_beat + 1'b1;
                     end
                  end
               end
               S_GAP: begin
                  r_presc <= w_tick ? '0 : r_presc + 1'b1;
                  if (w_gapEnd) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_gap   <= '0;
                  end else if (w_tick) begin
                     r_gap <= r_gap + 1'b1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tune_sequencer.sv
// Scoreboard bench for tune_sequencer: each queued note carries its expected span, first tone edge and rising-edge count.
module tb_tune_sequencer;

   localparam int P  = 4;
   localparam int BT = 8;
   localparam int G  = 2;

   logic        wb_clk_i   = 1'b0;
   logic        rst_n      = 1'b0;
   logic        enable     = 1'b0;
   logic        note_valid = 1'b0;
   logic [11:0] note_data  = 12'h000;
`ifdef TUNE_SEQ_LOOP_EN
   logic        loop       = 1'b0;
`endif
   logic        note_ready;
   logic        tone_out;
   logic        note_start;
   logic        busy;
   logic [3:0]  fifo_level;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int span;
      int first;
      int rising;
   } exp_t;

   exp_t sbQ[$];

   int  mCnt    = 0;
   int  mFirst  = 0;
   int  mRising = 0;
   bit  mActive = 1'b0;
   bit  mPrev   = 1'b0;

   logic [11:0] t2Data [8] = '{12'h010, 12'h020, 12'h000, 12'h050, 12'h031, 12'h012, 12'h0A0, 12'hFF0};
   int          t2Span [8] = '{40, 40, 40, 40, 72, 104, 40, 40};
   int          t2First[8] = '{4, 8, 0, 20, 12, 4, 0, 0};
   int          t2Rise [8] = '{4, 2, 0, 1, 3, 12, 0, 0};

   always #5 wb_clk_i = ~wb_clk_i;

   tune_sequencer #(
      .PRESCALE   (P),
      .BEAT_TICKS (BT),
      .GAP_TICKS  (G)
   ) dut (
      .wb_clk_i   (wb_clk_i),
      .rst_n      (rst_n),
      .enable     (enable),
      .note_valid (note_valid),
      .note_data  (note_data),
      .note_ready (note_ready),
`ifdef TUNE_SEQ_LOOP_EN
      .loop       (loop),
`endif
      .tone_out   (tone_out),
      .note_start (note_start),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic expectNote(input int span, input int first, input int rising);
      exp_t e;
      e.span   = span;
      e.first  = first;
      e.rising = rising;
      sbQ.push_back(e);
   endtask

   task automatic closeNote();
      exp_t e;
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL sb_underflow: got note of span %0d expected no note", mCnt);
      end else begin
         e = sbQ.pop_front();
         checkOutput("note_span", mCnt, e.span);
         checkOutput("note_first_edge", mFirst, e.first);
         checkOutput("note_rising_edges", mRising, e.rising);
      end
   endtask

   // Monitor: measures each note from its note_start until the next start or busy falls.
   always @(negedge wb_clk_i) begin
      if (!rst_n) begin
         mActive = 1'b0;
      end else begin
         if (mActive) begin
            mCnt++;
            if (tone_out && !mPrev) begin
               mRising++;
               if (mFirst == 0) mFirst = mCnt;
            end
            if (note_start || !busy) begin
               closeNote();
               mActive = 1'b0;
            end
         end
         if (note_start) begin
            mActive = 1'b1;
            mCnt    = 0;
            mFirst  = 0;
            mRising = 0;
         end
      end
      mPrev = tone_out;
   end

   task automatic applyStimulus(input logic [11:0] d, input int span, input int first,
                                input int rising, output bit acc);
      @(negedge wb_clk_i);
      note_valid = 1'b1;
      note_data  = d;
      acc        = note_ready;
      @(negedge wb_clk_i);
      note_valid = 1'b0;
      if (acc) expectNote(span, first, rising);
   endtask

   task automatic waitBusy(input int bound, input string name);
      int n = 0;
      while (!busy && n < bound) begin
         @(negedge wb_clk_i);
         n++;
      end
      checkOutput(name, int'(busy), 1);
   endtask

   task automatic waitIdle(input int bound, input string name);
      int n = 0;
      while (busy && n < bound) begin
         @(negedge wb_clk_i);
         n++;
      end
      checkOutput(name, int'(busy), 0);
   endtask

   task automatic waitNoteStart(input int bound, input string name);
      int n = 0;
      while (!note_start && n < bound) begin
         @(negedge wb_clk_i);
         n++;
      end
      checkOutput(name, int'(note_start), 1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_tone"}, int'(tone_out), 0);
      checkOutput({tag, "_note_start"}, int'(note_start), 0);
      checkOutput({tag, "_busy"}, int'(busy), 0);
      checkOutput({tag, "_level"}, int'(fifo_level), 0);
      checkOutput({tag, "_ready"}, int'(note_ready), 1);
   endtask

   initial begin
      bit acc;
      int starts;
      int n;

      // Reset
      rst_n = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      checkResetValues("reset");
      rst_n = 1'b1;

      // Single 2-beat note with hp=3
      applyStimulus(12'h031, 72, 12, 3, acc);
      checkOutput("t1_level", int'(fifo_level), 1);
      @(negedge wb_clk_i);
      enable = 1'b1;
      waitBusy(10, "t1_busy");
      waitIdle(200, "t1_idle");

      // Fill to full, reject ninth, then refill on the cycle after the first pop
      enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(t2Data[i], t2Span[i], t2First[i], t2Rise[i], acc);
      end
      checkOutput("t2_level_full", int'(fifo_level), 8);
      checkOutput("t2_ready_full", int'(note_ready), 0);
      applyStimulus(12'h021, 72, 8, 4, acc);
      checkOutput("t2_ninth_rejected", int'(acc), 0);
      checkOutput("t2_level_still_full", int'(fifo_level), 8);
      @(negedge wb_clk_i);
      note_valid = 1'b1;
      note_data  = 12'h021;
      enable     = 1'b1;
      @(negedge wb_clk_i);
      checkOutput("t2_level_after_pop", int'(fifo_level), 7);
      @(negedge wb_clk_i);
      note_valid = 1'b0;
      checkOutput("t2_level_refilled", int'(fifo_level), 8);
      expectNote(72, 8, 4);
      waitIdle(2000, "t2_drain_idle");
      checkOutput("t2_level_drained", int'(fifo_level), 0);

      // Rest followed by a note with no idle cycle in between
      enable = 1'b0;
      applyStimulus(12'h000, 40, 0, 0, acc);
      applyStimulus(12'h020, 40, 8, 2, acc);
      @(negedge wb_clk_i);
      enable = 1'b1;
      waitBusy(10, "t3_busy");
      starts = 0;
      n = 0;
      while (busy && n < 500) begin
         if (note_start) starts++;
         @(negedge wb_clk_i);
         n++;
      end
      checkOutput("t3_idle", int'(busy), 0);
      checkOutput("t3_back_to_back_starts", starts, 2);

      // Abort mid-PLAY, then resume with fresh counters
      enable = 1'b0;
      applyStimulus(12'h031, 21, 12, 1, acc);
      applyStimulus(12'h020, 40, 8, 2, acc);
      applyStimulus(12'h0FF, 520, 60, 4, acc);
      @(negedge wb_clk_i);
      enable = 1'b1;
      waitNoteStart(10, "t4_start");
      repeat (20) @(negedge wb_clk_i);
      enable = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("t4_abort_busy", int'(busy), 0);
      checkOutput("t4_abort_tone", int'(tone_out), 0);
      checkOutput("t4_abort_level", int'(fifo_level), 2);
      enable = 1'b1;
      waitBusy(10, "t4_resume_busy");
      waitIdle(1000, "t4_idle");
      checkOutput("t4_level_drained", int'(fifo_level), 0);

      // Reset mid-note with five notes still queued
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(12'h010, 40, 4, 4, acc);
      end
      @(negedge wb_clk_i);
      enable = 1'b1;
      waitNoteStart(10, "t5_start");
      checkOutput("t5_level_five", int'(fifo_level), 5);
      repeat (10) @(negedge wb_clk_i);
      rst_n = 1'b0;
      @(negedge wb_clk_i);
      sbQ.delete();
      checkResetValues("t5_midnote_reset");
      enable = 1'b0;
      rst_n  = 1'b1;
      n = 0;
      repeat (20) begin
         @(negedge wb_clk_i);
         if (tone_out) n++;
      end
      checkOutput("t5_no_residual_tone", n, 0);

`ifdef TUNE_SEQ_LOOP_EN
      // Looping playback: A,B,C repeat with the level unchanged by each pop
      loop = 1'b1;
      applyStimulus(12'h010, 40, 4, 4, acc);
      applyStimulus(12'h020, 40, 8, 2, acc);
      applyStimulus(12'h050, 40, 20, 1, acc);
      expectNote(40, 4, 4);
      expectNote(40, 8, 2);
      expectNote(40, 20, 1);
      expectNote(1, 0, 0);
      @(negedge wb_clk_i);
      enable = 1'b1;
      #1;
      checkOutput("t6_ready_on_loop_pop", int'(note_ready), 0);
      for (int k = 0; k < 7; k++) begin
         waitNoteStart(100, "t6_start");
         checkOutput("t6_loop_level", int'(fifo_level), 3);
         if (k < 6) @(negedge wb_clk_i);
      end
      enable = 1'b0;
      @(negedge wb_clk_i);
      loop = 1'b0;
      checkOutput("t6_stop_busy", int'(busy), 0);
      checkOutput("t6_level_kept", int'(fifo_level), 3);
`endif

      repeat (5) @(negedge wb_clk_i);
      checkOutput("sb_empty", sbQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
